wb_stage: RTL and testbench
===========================

# wb_stage

Writeback stage of the pipelined RV32I core: holds the MEM/WB pipeline register, aligns and sign- or zero-extends load data, selects the writeback source, and drives the register file's write port. With register-file bypass enabled, decode observes the result in the same cycle. The stage also counts retired instructions for the instret CSR.

## Interface

Parameters:
- CNT_WIDTH, default 64: width of the retired-instruction counter.

Ports:
- i_clk  in  1  global clock; all state updates on the rising edge.
- i_rst  in  1  reset, asynchronous and active-high; clears all state immediately.
- i_valid  in  1  MEM stage presents an instruction this cycle.
- i_stall  in  1  hazard unit holds WB; the pipeline register keeps its contents.
- i_rd_wen  in  1  instruction writes rd.
- i_rd_waddr  in  5  destination register.
- i_wb_sel  in  2  source: 0 ALU, 1 load, 2 PC+4, 3 immediate.
- i_alu_result  in  32  ALU output.
- i_pc_plus4  in  32  link value for JAL/JALR.
- i_imm  in  32  LUI immediate.
- i_load_data  in  32  raw aligned data-memory word.
- i_funct3  in  3  load width and sign.
- i_addr_lo  in  2  low bits of the load address.
- o_rd_wen  out  1  register-file write enable.
- o_rd_waddr  out  5  register-file write address.
- o_rd_wdata  out  32  register-file write data.
- o_retire  out  1  one-cycle pulse per retired instruction.
- o_instret  out  CNT_WIDTH  retired-instruction count.

## Operation

- Pipeline register: holds valid, rd_wen, waddr, wb_sel, the four data inputs, funct3 and addr_lo, plus a `done` flag.
- Capture: on each edge with i_stall low, load all fields from the inputs and clear done.
- Stall: on an edge with i_stall high, hold all fields, ignore the inputs, and set done if valid. The upstream stage must hold its outputs while i_stall is high.
- Write and retire once: o_rd_wen = valid & rd_wen & (waddr != 0) & !done, and o_retire = valid & !done. A stalled instruction therefore writes and retires only in its first WB cycle.
- Writes to x0: o_rd_wen stays low, but the instruction still retires.
- Load alignment, byte lane = addr_lo, half lane = addr_lo[1]:
  - LB (000) sign-extends the selected byte.
  - LBU (100) zero-extends the selected byte.
  - LH (001) sign-extends the selected half.
  - LHU (101) zero-extends the selected half.
  - LW (010) passes the word and ignores addr_lo.
  - Codes 011, 110 and 111 produce 32'd0.
  - Misalignment is trapped upstream and is not checked here.
- o_rd_wdata: mux output selected by wb_sel. It is valid whenever valid is high, even if o_rd_wen is low.
- o_rd_waddr: driven directly from the register.
- o_instret: increments by 1 on each edge where o_retire is high and wraps from all-ones to 0.

## Timing

- Reset values: valid=0, done=0, counter=0. Therefore o_rd_wen=0, o_retire=0, o_instret=0. o_rd_waddr and o_rd_wdata are 0.
- Reset is asynchronous: outputs clear without waiting for a clock edge. An in-flight instruction is dropped and neither written nor counted.
- Latency: inputs sampled at edge k give o_rd_wen and o_retire during cycle k..k+1. The register file commits at edge k+1, and o_instret reflects the retire after edge k+1.
- Write and retire outputs are combinational from registered state only, with no input-to-output combinational path.
- i_valid low with i_stall low captures a bubble: outputs low next cycle.
- i_stall high for N cycles: one write and one retire pulse in the first cycle, then low for the remaining N-1 cycles.

## Structure

- Shared package `core_pkg` holds:
  - WB_SEL_ALU/LOAD/PC4/IMM constants (2-bit).
  - LOAD_LB/LH/LW/LBU/LHU funct3 constants.
- Sub-module `load_align`: purely combinational. Inputs are word, funct3 and addr_lo; output is the 32-bit result. It is instantiated once on the registered fields.

## Test plan

- Reset: assert i_rst mid-cycle with a valid instruction held -> all outputs 0 immediately; o_instret=0 after release.
- ALU writeback: valid, rd=5, wb_sel=0, alu=32'h1234_5678 -> one cycle with o_rd_wen=1, waddr=5, wdata=32'h1234_5678; o_instret=1.
- Load extension: word 32'h80FF_7F01.
  - LB with addr_lo=2 -> 32'hFFFF_FFFF.
  - LBU with addr_lo=3 -> 32'h0000_0080.
  - LH with addr_lo=2 -> 32'hFFFF_80FF.
  - LHU with addr_lo=0 -> 32'h0000_7F01.
  - funct3=011 -> 0.
- Stall: valid rd=7 instruction followed by i_stall high for 3 cycles -> exactly one o_rd_wen and one o_retire pulse; o_instret advances by 1 only.
- x0 and bubbles: rd=0 with wen=1 -> o_rd_wen=0, o_retire=1; a bubble -> neither.
- Wrap: CNT_WIDTH=4, 17 retires -> o_instret=1.

Source files
------------

// File: rtl/core_pkg.sv
// Shared encodings for the RV32I core: writeback source selects and load funct3 codes.
package core_pkg;

  localparam logic [1:0] WB_SEL_ALU  = 2'd0;
  localparam logic [1:0] WB_SEL_LOAD = 2'd1;
  localparam logic [1:0] WB_SEL_PC4  = 2'd2;
  localparam logic [1:0] WB_SEL_IMM  = 2'd3;

  localparam logic [2:0] LOAD_LB  = 3'b000;
  localparam logic [2:0] LOAD_LH  = 3'b001;
  localparam logic [2:0] LOAD_LW  = 3'b010;
  localparam logic [2:0] LOAD_LBU = 3'b100;
  localparam logic [2:0] LOAD_LHU = 3'b101;

endpackage

// File: rtl/load_align.sv
// Load data alignment: picks the addressed byte/half from the memory word and extends it.
module load_align
  import core_pkg::*;
(
  input  logic [31:0] word,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = 8'd0;
    case (addr_lo)
      2'd0: byte_sel = word[7:0];
      2'd1: byte_sel = word[15:8];
      2'd2: byte_sel = word[23:16];
      2'd3: byte_sel = word[31:24];
      default: byte_sel = 8'd0;
    endcase
  end

  assign half_sel = addr_lo[1] ? word[31:16] : word[15:0];

  always_comb begin
    result = 32'd0;
    case (funct3)
      LOAD_LB:  result = {{24{byte_sel[7]}}, byte_sel};
      LOAD_LBU: result = {24'd0, byte_sel};
      LOAD_LH:  result = {{16{half_sel[15]}}, half_sel};
      LOAD_LHU: result = {16'd0, half_sel};
      LOAD_LW:  result = word;
      default:  result = 32'd0;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: MEM/WB register, writeback mux, register-file write port and instret counter.
module wb_stage
  import core_pkg::*;
#(
  parameter int CNT_WIDTH = 64
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  input  logic                 i_stall,
  input  logic                 i_rd_wen,
  input  logic [4:0]           i_rd_waddr,
  input  logic [1:0]           i_wb_sel,
  input  logic [31:0]          i_alu_result,
  input  logic [31:0]          i_pc_plus4,
  input  logic [31:0]          i_imm,
  input  logic [31:0]          i_load_data,
  input  logic [2:0]           i_funct3,
  input  logic [1:0]           i_addr_lo,
  output logic                 o_rd_wen,
  output logic [4:0]           o_rd_waddr,
  output logic [31:0]          o_rd_wdata,
  output logic                 o_retire,
  output logic [CNT_WIDTH-1:0] o_instret
);

  logic                 valid_q;
  logic                 done_q;
  logic                 rd_wen_q;
  logic [4:0]           waddr_q;
  logic [1:0]           wb_sel_q;
  logic [31:0]          alu_q;
  logic [31:0]          pc4_q;
  logic [31:0]          imm_q;
  logic [31:0]          load_q;
  logic [2:0]           funct3_q;
  logic [1:0]           addr_lo_q;
  logic [CNT_WIDTH-1:0] instret_q;
  logic [31:0]          load_val;

  // done marks an instruction that already wrote/retired while held by a stall
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      rd_wen_q  <= 1'b0;
      waddr_q   <= 5'd0;
      wb_sel_q  <= WB_SEL_ALU;
      alu_q     <= 32'd0;
      pc4_q     <= 32'd0;
      imm_q     <= 32'd0;
      load_q    <= 32'd0;
      funct3_q  <= 3'd0;
      addr_lo_q <= 2'd0;
    end else if (i_stall) begin
      done_q <= done_q | valid_q;
    end else begin
      valid_q   <= i_valid;
      done_q    <= 1'b0;
      rd_wen_q  <= i_rd_wen;
      waddr_q   <= i_rd_waddr;
      wb_sel_q  <= i_wb_sel;
      alu_q     <= i_alu_result;
      pc4_q     <= i_pc_plus4;
      imm_q     <= i_imm;
      load_q    <= i_load_data;
      funct3_q  <= i_funct3;
      addr_lo_q <= i_addr_lo;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      instret_q <= '0;
    end else if (o_retire) begin
      instret_q <= instret_q + CNT_WIDTH'(1);
    end
  end

  load_align u_load_align (
    .word    (load_q),
    .funct3  (funct3_q),
    .addr_lo (addr_lo_q),
    .result  (load_val)
  );

  always_comb begin
    o_rd_wdata = alu_q;
    case (wb_sel_q)
      WB_SEL_ALU:  o_rd_wdata = alu_q;
      WB_SEL_LOAD: o_rd_wdata = load_val;
      WB_SEL_PC4:  o_rd_wdata = pc4_q;
      WB_SEL_IMM:  o_rd_wdata = imm_q;
      default:     o_rd_wdata = alu_q;
    endcase
  end

  assign o_retire   = valid_q & ~done_q;
  assign o_rd_wen   = valid_q & rd_wen_q & (waddr_q != 5'd0) & ~done_q;
  assign o_rd_waddr = waddr_q;
  assign o_instret  = instret_q;

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: driver pushes expected outputs, negedge monitor pops and compares.
module tb_wb_stage;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_valid = 1'b0, i_stall = 1'b0, i_rd_wen = 1'b0;
  logic [4:0]  i_rd_waddr = '0;
  logic [1:0]  i_wb_sel = '0;
  logic [31:0] i_alu_result = '0, i_pc_plus4 = '0, i_imm = '0, i_load_data = '0;
  logic [2:0]  i_funct3 = '0;
  logic [1:0]  i_addr_lo = '0;

  logic        o_rd_wen, o_retire, w_rd_wen, w_retire;
  logic [4:0]  o_rd_waddr, w_rd_waddr;
  logic [31:0] o_rd_wdata, w_rd_wdata;
  logic [63:0] o_instret;
  logic [3:0]  w_instret;

  wb_stage #(.CNT_WIDTH(64)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_stall(i_stall),
    .i_rd_wen(i_rd_wen), .i_rd_waddr(i_rd_waddr), .i_wb_sel(i_wb_sel),
    .i_alu_result(i_alu_result), .i_pc_plus4(i_pc_plus4), .i_imm(i_imm),
    .i_load_data(i_load_data), .i_funct3(i_funct3), .i_addr_lo(i_addr_lo),
    .o_rd_wen(o_rd_wen), .o_rd_waddr(o_rd_waddr), .o_rd_wdata(o_rd_wdata),
    .o_retire(o_retire), .o_instret(o_instret));

  wb_stage #(.CNT_WIDTH(4)) dut_w (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_stall(i_stall),
    .i_rd_wen(i_rd_wen), .i_rd_waddr(i_rd_waddr), .i_wb_sel(i_wb_sel),
    .i_alu_result(i_alu_result), .i_pc_plus4(i_pc_plus4), .i_imm(i_imm),
    .i_load_data(i_load_data), .i_funct3(i_funct3), .i_addr_lo(i_addr_lo),
    .o_rd_wen(w_rd_wen), .o_rd_waddr(w_rd_waddr), .o_rd_wdata(w_rd_wdata),
    .o_retire(w_retire), .o_instret(w_instret));

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic              valid;
    logic              wen;
    logic              retire;
    logic [4:0]        waddr;
    logic [31:0]       wdata;
    longint unsigned   instret;
  } exp_t;

  exp_t            q[$];
  exp_t            last;
  longint unsigned total = 0;
  int              n_vec = 0;
  int              n_bad = 0;
  bit              mon_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  // Reference load extension computed arithmetically from the byte/half value
  function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [2:0] f3,
                                           input logic [1:0] alo);
    int unsigned w = word;
    int unsigned b = (w >> (8 * int'(alo))) % 256;
    int unsigned h = (w >> (16 * (int'(alo) / 2))) % 65536;
    case (f3)
      3'd0:    return (b >= 128) ? 32'(b + 32'hFFFF_FF00) : 32'(b);
      3'd4:    return 32'(b);
      3'd1:    return (h >= 32768) ? 32'(h + 32'hFFFF_0000) : 32'(h);
      3'd5:    return 32'(h);
      3'd2:    return word;
      default: return 32'd0;
    endcase
  endfunction

  task automatic issue(input bit v, input bit wen, input logic [4:0] rd, input logic [1:0] sel,
                       input logic [31:0] alu, input logic [31:0] pc4, input logic [31:0] imm,
                       input logic [31:0] ld, input logic [2:0] f3, input logic [1:0] alo,
                       input bit stall);
    exp_t e;
    i_valid = v; i_rd_wen = wen; i_rd_waddr = rd; i_wb_sel = sel;
    i_alu_result = alu; i_pc_plus4 = pc4; i_imm = imm; i_load_data = ld;
    i_funct3 = f3; i_addr_lo = alo; i_stall = stall;
    if (stall) begin
      e = last;
      e.wen = 1'b0;
      e.retire = 1'b0;
    end else begin
      e.valid  = v;
      e.retire = v;
      e.wen    = v && wen && (rd != 5'd0);
      e.waddr  = rd;
      case (sel)
        2'd0: e.wdata = alu;
        2'd1: e.wdata = ref_load(ld, f3, alo);
        2'd2: e.wdata = pc4;
        default: e.wdata = imm;
      endcase
    end
    e.instret = total;
    q.push_back(e);
    if (e.retire) total++;
    last = e;
    @(posedge i_clk);
    #1;
  endtask

  task automatic ld(input logic [2:0] f3, input logic [1:0] alo);
    issue(1, 1, 5'd10, 2'd1, 32'hAAAA_AAAA, 0, 0, 32'h80FF_7F01, f3, alo, 0);
  endtask

  always @(negedge i_clk) begin
    if (mon_en && q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("rd_wen", 64'(o_rd_wen), 64'(e.wen));
      chk("retire", 64'(o_retire), 64'(e.retire));
      chk("rd_waddr", 64'(o_rd_waddr), 64'(e.waddr));
      if (e.valid) chk("rd_wdata", 64'(o_rd_wdata), 64'(e.wdata));
      chk("instret", o_instret, 64'(e.instret));
      chk("instret_w4", 64'(w_instret), 64'(e.instret % 16));
    end
  end

  initial begin
    exp_t er;
    #3;
    chk("rst_rd_wen", 64'(o_rd_wen), 64'd0);
    chk("rst_retire", 64'(o_retire), 64'd0);
    chk("rst_instret", o_instret, 64'd0);
    chk("rst_waddr", 64'(o_rd_waddr), 64'd0);
    chk("rst_wdata", 64'(o_rd_wdata), 64'd0);
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    er.valid = 0; er.wen = 0; er.retire = 0; er.waddr = 0; er.wdata = 0; er.instret = 0;
    last = er;
    q.push_back(er);
    mon_en = 1'b1;

    issue(1, 1, 5'd5, 2'd0, 32'h1234_5678, 32'h4, 32'h0, 32'h0, 3'd2, 2'd0, 0);
    ld(3'b000, 2'd2);
    ld(3'b100, 2'd3);
    ld(3'b001, 2'd2);
    ld(3'b101, 2'd0);
    ld(3'b011, 2'd1);
    ld(3'b010, 2'd3);
    issue(1, 1, 5'd7, 2'd2, 32'h0, 32'h0000_1004, 32'h0, 32'h0, 3'd0, 2'd0, 0);
    repeat (3) issue(1, 1, 5'd7, 2'd2, 32'h0, 32'h0000_1004, 32'h0, 32'h0, 3'd0, 2'd0, 1);
    issue(1, 1, 5'd0, 2'd3, 32'h0, 32'h0, 32'hABCD_E000, 32'h0, 3'd0, 2'd0, 0);
    issue(0, 1, 5'd3, 2'd0, 32'h5, 32'h0, 32'h0, 32'h0, 3'd0, 2'd0, 0);
    repeat (2) issue(0, 1, 5'd3, 2'd0, 32'h5, 32'h0, 32'h0, 32'h0, 3'd0, 2'd0, 1);

    for (int i = 0; i < 400; i++) begin
      issue($urandom_range(3) != 0, $urandom_range(1),
            ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom),
            2'($urandom), $urandom, $urandom, $urandom, $urandom,
            3'($urandom), 2'($urandom), $urandom_range(3) == 0);
    end

    issue(1, 1, 5'd9, 2'd0, 32'hDEAD_BEEF, 0, 0, 0, 3'd0, 2'd0, 0);
    @(negedge i_clk); #1;
    chk("queue_drained", 64'(q.size()), 64'd0);
    mon_en = 1'b0;
    chk("pre_rst_wen", 64'(o_rd_wen), 64'd1);

    i_rst = 1'b1;
    #1;
    chk("async_rst_wen", 64'(o_rd_wen), 64'd0);
    chk("async_rst_retire", 64'(o_retire), 64'd0);
    chk("async_rst_instret", o_instret, 64'd0);
    chk("async_rst_instret_w4", 64'(w_instret), 64'd0);
    chk("async_rst_waddr", 64'(o_rd_waddr), 64'd0);
    chk("async_rst_wdata", 64'(o_rd_wdata), 64'd0);
    @(posedge i_clk); #2;
    i_rst = 1'b0;
    i_valid = 1'b0;
    #1;
    chk("post_rst_instret", o_instret, 64'd0);
    @(posedge i_clk); #1;
    chk("post_rst_retire", 64'(o_retire), 64'd0);
    chk("post_rst_instret2", o_instret, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
